// File: rtl/watch_time_datapath.sv
// rtl/watch_time_datapath.sv - watch and stopwatch time counters with 100 Hz prescalers and display select
// Watch takes per-field edits; stopwatch takes run/clear; output shows the selected counter.

module watch_field_step #(
    parameter int             W   = 7,
    parameter logic [W-1:0]   MAX = '1
) (
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic [W-1:0] nxt_o,
    output logic         at_max_o
);
    always_comb begin
        at_max_o = (val_i == MAX);
        if (dec_i) begin
            nxt_o = (val_i == '0) ? MAX : val_i - W'(1);
        end else begin
            nxt_o = at_max_o ? '0 : val_i + W'(1);
        end
    end
endmodule

module watch_time_datapath #(
    parameter int TICK_DIV  = 1_000_000,
    parameter int INIT_HOUR = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_run_stop,
    input  logic       i_clear,
    input  logic [1:0] i_edit_msec,
    input  logic [1:0] i_edit_sec,
    input  logic [1:0] i_edit_min,
    input  logic [1:0] i_edit_hour,
    input  logic       i_watch_select,
    output logic [6:0] o_msec,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour
);
    localparam int              CW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]   TICK_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] w_cnt_q, w_cnt_d;
    logic [CW-1:0] s_cnt_q, s_cnt_d;

    logic [6:0] w_msec_q, w_msec_d, s_msec_q, s_msec_d;
    logic [5:0] w_sec_q,  w_sec_d,  s_sec_q,  s_sec_d;
    logic [5:0] w_min_q,  w_min_d,  s_min_q,  s_min_d;
    logic [4:0] w_hour_q, w_hour_d, s_hour_q, s_hour_d;

    logic [6:0] w_msec_nxt, s_msec_nxt;
    logic [5:0] w_sec_nxt,  s_sec_nxt;
    logic [5:0] w_min_nxt,  s_min_nxt;
    logic [4:0] w_hour_nxt, s_hour_nxt;
    logic       w_msec_max, w_sec_max, w_min_max, w_hour_max;
    logic       s_msec_max, s_sec_max, s_min_max, s_hour_max;

    logic w_tick;
    logic s_tick;
    logic any_edit;

    assign w_tick   = (w_cnt_q == TICK_LAST);
    assign s_tick   = i_run_stop && !i_clear && (s_cnt_q == TICK_LAST);
    // Bit 0 marks a valid code (01 or 11); bit 1 then selects decrement.
    assign any_edit = i_edit_msec[0] | i_edit_sec[0] | i_edit_min[0] | i_edit_hour[0];

    watch_field_step #(.W(7), .MAX(7'd99)) u_w_msec (
        .val_i(w_msec_q), .dec_i(i_edit_msec == 2'b11), .nxt_o(w_msec_nxt), .at_max_o(w_msec_max));
    watch_field_step #(.W(6), .MAX(6'd59)) u_w_sec (
        .val_i(w_sec_q),  .dec_i(i_edit_sec == 2'b11),  .nxt_o(w_sec_nxt),  .at_max_o(w_sec_max));
    watch_field_step #(.W(6), .MAX(6'd59)) u_w_min (
        .val_i(w_min_q),  .dec_i(i_edit_min == 2'b11),  .nxt_o(w_min_nxt),  .at_max_o(w_min_max));
    watch_field_step #(.W(5), .MAX(5'd23)) u_w_hour (
        .val_i(w_hour_q), .dec_i(i_edit_hour == 2'b11), .nxt_o(w_hour_nxt), .at_max_o(w_hour_max));

    watch_field_step #(.W(7), .MAX(7'd99)) u_s_msec (
        .val_i(s_msec_q), .dec_i(1'b0), .nxt_o(s_msec_nxt), .at_max_o(s_msec_max));
    watch_field_step #(.W(6), .MAX(6'd59)) u_s_sec (
        .val_i(s_sec_q),  .dec_i(1'b0), .nxt_o(s_sec_nxt),  .at_max_o(s_sec_max));
    watch_field_step #(.W(6), .MAX(6'd59)) u_s_min (
        .val_i(s_min_q),  .dec_i(1'b0), .nxt_o(s_min_nxt),  .at_max_o(s_min_max));
    watch_field_step #(.W(5), .MAX(5'd23)) u_s_hour (
        .val_i(s_hour_q), .dec_i(1'b0), .nxt_o(s_hour_nxt), .at_max_o(s_hour_max));

    always_comb begin
        w_cnt_d = w_tick ? '0 : w_cnt_q + CW'(1);
        s_cnt_d = s_cnt_q;
        if (i_clear) begin
            s_cnt_d = '0;
        end else if (i_run_stop) begin
            s_cnt_d = (s_cnt_q == TICK_LAST) ? '0 : s_cnt_q + CW'(1);
        end
    end

    // Any valid edit swallows a coincident tick; the prescaler is unaffected.
    always_comb begin
        w_msec_d = w_msec_q;
        w_sec_d  = w_sec_q;
        w_min_d  = w_min_q;
        w_hour_d = w_hour_q;
        if (any_edit) begin
            if (i_edit_msec[0]) w_msec_d = w_msec_nxt;
            if (i_edit_sec[0])  w_sec_d  = w_sec_nxt;
            if (i_edit_min[0])  w_min_d  = w_min_nxt;
            if (i_edit_hour[0]) w_hour_d = w_hour_nxt;
        end else if (w_tick) begin
            w_msec_d = w_msec_nxt;
            if (w_msec_max) begin
                w_sec_d = w_sec_nxt;
                if (w_sec_max) begin
                    w_min_d = w_min_nxt;
                    if (w_min_max) w_hour_d = w_hour_nxt;
                end
            end
        end
    end

    always_comb begin
        s_msec_d = s_msec_q;
        s_sec_d  = s_sec_q;
        s_min_d  = s_min_q;
        s_hour_d = s_hour_q;
        if (i_clear) begin
            s_msec_d = '0;
            s_sec_d  = '0;
            s_min_d  = '0;
            s_hour_d = '0;
        end else if (s_tick) begin
            s_msec_d = s_msec_nxt;
            if (s_msec_max) begin
                s_sec_d = s_sec_nxt;
                if (s_sec_max) begin
                    s_min_d = s_min_nxt;
                    if (s_min_max) s_hour_d = s_hour_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_cnt_q  <= '0;
            s_cnt_q  <= '0;
            w_msec_q <= '0;
            w_sec_q  <= '0;
            w_min_q  <= '0;
            w_hour_q <= 5'(INIT_HOUR);
            s_msec_q <= '0;
            s_sec_q  <= '0;
            s_min_q  <= '0;
            s_hour_q <= '0;
        end else begin
            w_cnt_q  <= w_cnt_d;
            s_cnt_q  <= s_cnt_d;
            w_msec_q <= w_msec_d;
            w_sec_q  <= w_sec_d;
            w_min_q  <= w_min_d;
            w_hour_q <= w_hour_d;
            s_msec_q <= s_msec_d;
            s_sec_q  <= s_sec_d;
            s_min_q  <= s_min_d;
            s_hour_q <= s_hour_d;
        end
    end

    always_comb begin
        if (i_watch_select) begin
            o_msec = s_msec_q;
            o_sec  = s_sec_q;
            o_min  = s_min_q;
            o_hour = s_hour_q;
        end else begin
            o_msec = w_msec_q;
            o_sec  = w_sec_q;
            o_min  = w_min_q;
            o_hour = w_hour_q;
        end
    end

    logic unused_max;
    assign unused_max = w_hour_max ^ s_hour_max;
endmodule

// File: tb/tb_watch_time_datapath.sv
// tb/tb_watch_time_datapath.sv - directed vector bench for watch_time_datapath
module tb_watch_time_datapath;
    logic       clk = 1'b0;
    logic       reset;
    logic       run_stop, clear_r, sel;
    logic [1:0] e_msec, e_sec, e_min, e_hour;
    logic [6:0] o_msec;
    logic [5:0] o_sec, o_min;
    logic [4:0] o_hour;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         ncyc;
        logic [1:0] eh, em, es, ems;
        logic       run, clr, sel;
        logic [4:0] h;
        logic [5:0] m, s;
        logic [6:0] ms;
    } vec_t;

    vec_t vecs[$];

    watch_time_datapath #(.TICK_DIV(4), .INIT_HOUR(12)) dut (
        .clk(clk), .reset(reset), .i_run_stop(run_stop), .i_clear(clear_r),
        .i_edit_msec(e_msec), .i_edit_sec(e_sec), .i_edit_min(e_min), .i_edit_hour(e_hour),
        .i_watch_select(sel), .o_msec(o_msec), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour));

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [4:0] h, input logic [5:0] m,
                         input logic [5:0] s, input logic [6:0] ms);
        n_tests++;
        if ({o_hour, o_min, o_sec, o_msec} !== {h, m, s, ms}) begin
            n_fail++;
            $display("FAIL %s: got %0d:%0d:%0d.%0d expected %0d:%0d:%0d.%0d",
                     name, o_hour, o_min, o_sec, o_msec, h, m, s, ms);
        end
    endtask

    initial begin
        reset = 1'b1; run_stop = 0; clear_r = 0; sel = 0;
        e_msec = 0; e_sec = 0; e_min = 0; e_hour = 0;

        //           n    eh     em     es     ems   run clr sel  h   m   s   ms
        vecs.push_back('{0,   2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 12,  0,  0,  0});
        vecs.push_back('{0,   2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1,  0,  0,  0,  0});
        vecs.push_back('{3,   2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 12,  0,  0,  0});
        vecs.push_back('{1,   2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 12,  0,  0,  1});
        vecs.push_back('{396, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 12,  0,  1,  0});
        vecs.push_back('{1,   2'b01, 2'b11, 2'b11, 2'b11, 0, 0, 0, 13, 59,  0, 99});
        vecs.push_back('{1,   2'b01, 2'b00, 2'b11, 2'b00, 0, 0, 0, 14, 59, 59, 99});
        vecs.push_back('{9,   2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 23, 59, 59, 99});
        vecs.push_back('{1,   2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0,  0,  0,  0,  0});
        vecs.push_back('{3,   2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0,  0,  0,  0,  0});
        vecs.push_back('{1,   2'b00, 2'b00, 2'b11, 2'b00, 0, 0, 0,  0,  0, 59,  0});
        vecs.push_back('{1,   2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 0,  0,  0,  0,  0});
        vecs.push_back('{1,   2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0, 23,  0,  0,  0});
        vecs.push_back('{2,   2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 23,  0,  0,  1});
        vecs.push_back('{3,   2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 23,  0,  0,  1});
        vecs.push_back('{1,   2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 0, 23,  1,  0,  1});
        vecs.push_back('{4,   2'b10, 2'b10, 2'b00, 2'b10, 0, 0, 0, 23,  1,  0,  2});
        vecs.push_back('{3,   2'b00, 2'b00, 2'b00, 2'b11, 0, 0, 0, 23,  1,  0, 99});
        vecs.push_back('{10,  2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 1,  0,  0,  0,  2});
        vecs.push_back('{20,  2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1,  0,  0,  0,  2});
        vecs.push_back('{6,   2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 1,  0,  0,  0,  4});
        vecs.push_back('{0,   2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 23,  1,  1,  8});

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            e_hour = vecs[i].eh; e_min = vecs[i].em; e_sec = vecs[i].es; e_msec = vecs[i].ems;
            run_stop = vecs[i].run; clear_r = vecs[i].clr; sel = vecs[i].sel;
            if (vecs[i].ncyc > 0) step(vecs[i].ncyc);
            else #1;
            check($sformatf("vec%0d", i), vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].ms);
        end
        e_hour = 0; e_min = 0; e_sec = 0; e_msec = 0;

        // Clear while running: zero next cycle, next increment TICK_DIV cycles later.
        sel = 1; run_stop = 1; clear_r = 0;
        step(2);
        check("sw_pre_clear", 0, 0, 0, 4);
        clear_r = 1;
        step(1);
        check("sw_clear_zero", 0, 0, 0, 0);
        clear_r = 0;
        step(3);
        check("sw_after_clear_3cyc", 0, 0, 0, 0);
        step(1);
        check("sw_after_clear_4cyc", 0, 0, 0, 1);
        sel = 0;
        #1;
        check("watch_unaffected_by_clear", 23, 1, 1, 10);

        // Asynchronous reset mid-cycle, then first tick after release.
        #2 reset = 1'b1;
        #1;
        check("async_reset_watch", 12, 0, 0, 0);
        sel = 1;
        #1;
        check("async_reset_sw", 0, 0, 0, 0);
        run_stop = 0; sel = 0;
        @(posedge clk);
        #1 reset = 1'b0;
        step(3);
        check("post_reset_3cyc", 12, 0, 0, 0);
        step(1);
        check("post_reset_first_tick", 12, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
